ir_fetch: RTL



---
 rtl/ir_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ir_fetch.sv
`default_nettype none
// ============================================================================
// ir_fetch : fetches device/address instruction pairs into a small IR FIFO
// Rev 1.0
// ============================================================================
module ir_fetch #(
   parameter int DATA_WIDTH = 16,
   parameter int IR_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_ir_regfile_en,
   input  logic [DATA_WIDTH-1:0] i_ir_pointer,
   input  logic                  i_ir_pointer_valid,
   output logic                  o_mem_req,
   output logic [DATA_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_inst_valid,
   input  logic                  i_inst_ready,
   output logic [DATA_WIDTH-1:0] o_device,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic                  o_busy
);

   localparam int PTR_W = (IR_DEPTH > 1) ? $clog2(IR_DEPTH) : 1;
   localparam int CNT_W = $clog2(IR_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IR_DEPTH);

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_DEV     = 2'd1,
      F_ADDR    = 2'd2,
      F_DISCARD = 2'd3
   } fetch_state_e;

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] dev_hold_q, dev_hold_d;
   logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] fifo_dev_q  [IR_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_addr_q [IR_DEPTH];

   logic mode_work;
   logic mode_rst;
   logic flush;
   logic push;
   logic pop;
   logic inst_valid;

   assign mode_work  = (i_ir_regfile_en == 2'b10);
   assign mode_rst   = (i_ir_regfile_en == 2'b01);
   assign flush      = i_ir_pointer_valid | mode_rst;
   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid & i_inst_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      dev_hold_d = dev_hold_q;
      push       = 1'b0;
      case (state_q)
         F_IDLE: begin
            if (mode_work && (count_q < DEPTH_C) && !i_ir_pointer_valid)
               state_d = F_DEV;
         end
         F_DEV: begin
            if (flush) begin
               state_d = i_mem_ack ? F_IDLE : F_DISCARD;
            end else if (i_mem_ack) begin
               dev_hold_d = i_mem_rdata;
               pc_d       = pc_q + DATA_WIDTH'(1);
               state_d    = F_ADDR;
            end
         end
         F_ADDR: begin
            if (flush) begin
               state_d = i_mem_ack ? F_IDLE : F_DISCARD;
            end else if (i_mem_ack) begin
               push    = 1'b1;
               pc_d    = pc_q + DATA_WIDTH'(1);
               state_d = F_IDLE;
            end
         end
         F_DISCARD: begin
            if (i_mem_ack)
               state_d = F_IDLE;
         end
         default: state_d = F_IDLE;
      endcase
      if (flush)
         pc_d = i_ir_pointer;
      // A discarded read keeps presenting its original address; pc already points at the jump target.
      mem_addr_d = (state_d == F_DISCARD) ? mem_addr_q : pc_d;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= F_IDLE;
         pc_q       <= '0;
         dev_hold_q <= '0;
         mem_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dev_hold_q <= dev_hold_d;
         mem_addr_q <= mem_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dev_q[wr_ptr_q]  <= dev_hold_q;
         fifo_addr_q[wr_ptr_q] <= i_mem_rdata;
      end
   end

   assign o_mem_req    = (state_q != F_IDLE);
   assign o_busy       = (state_q != F_IDLE);
   assign o_mem_addr   = mem_addr_q;
   assign o_inst_valid = inst_valid;
   assign o_device     = inst_valid ? fifo_dev_q[rd_ptr_q]  : '0;
   assign o_address    = inst_valid ? fifo_addr_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire
